// File: rtl/round_share_arb.sv
// Arbitrates four requesters onto one shared rounding unit through a 2-stage pipeline.
// Define ROUND_ARB_FIXED_PRIO_EN for fixed priority (0 highest); default is round-robin.
module round_share_arb (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req_valid,
  output logic [3:0]   req_ready,
  input  logic [255:0] req_mant,
  input  logic [31:0]  req_k,
  output logic [63:0]  ru_mant,
  output logic [7:0]   ru_k,
  input  logic [31:0]  ru_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [31:0]  rsp_data,
  output logic [1:0]   rsp_id
);

  logic        s1_valid_q,  s1_valid_d;
  logic [63:0] ru_mant_q,   ru_mant_d;
  logic [7:0]  ru_k_q,      ru_k_d;
  logic [1:0]  s1_id_q,     s1_id_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q,  rsp_data_d;
  logic [1:0]  rsp_id_q,    rsp_id_d;

  logic       s2_adv;
  logic       s1_adv;
  logic       gnt_found;
  logic [1:0] gnt_id;
  logic [3:0] gnt_vec;
  logic       accept;

  assign s2_adv = !rsp_valid_q || rsp_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

`ifdef ROUND_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_id    = i[1:0];
      end
    end
  end
`else
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] idx;

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = 2'd0;
    idx       = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr_q + i[1:0];
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = gnt_id + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= 2'd0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  // rst_n gates the grant so nothing is offered while the block is held in reset
  always_comb begin
    gnt_vec         = 4'b0000;
    gnt_vec[gnt_id] = gnt_found;
  end

  assign accept    = gnt_found && s1_adv && rst_n;
  assign req_ready = accept ? gnt_vec : 4'b0000;

  always_comb begin
    s1_valid_d = s1_valid_q;
    ru_mant_d  = ru_mant_q;
    ru_k_d     = ru_k_q;
    s1_id_d    = s1_id_q;
    if (s1_adv) begin
      s1_valid_d = accept;
      if (accept) begin
        ru_mant_d = req_mant[{gnt_id, 6'b0} +: 64];
        ru_k_d    = req_k[{gnt_id, 3'b0} +: 8];
        s1_id_d   = gnt_id;
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    if (s2_adv) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_data_d = ru_result;
        rsp_id_d   = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      ru_mant_q   <= 64'd0;
      ru_k_q      <= 8'd0;
      s1_id_q     <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_id_q    <= 2'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      ru_mant_q   <= ru_mant_d;
      ru_k_q      <= ru_k_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign ru_mant   = ru_mant_q;
  assign ru_k      = ru_k_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_round_share_arb.sv
// Bench for round_share_arb: directed stimulus with a response scoreboard and a
// truncating rounding-unit model (26 fraction bits at k=0, one fewer per unit of |k|).
module tb_round_share_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [255:0] req_mant;
  logic [31:0]  req_k;
  logic [63:0]  ru_mant;
  logic [7:0]   ru_k;
  logic [31:0]  ru_result;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_id;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  // Per-requester operands and their hand-computed rounded results
  localparam logic [63:0] M0 = 64'hA5A5_F0F0_1234_5678;
  localparam logic [63:0] M1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] M2 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] M3 = 64'hDEAD_BEEF_0000_0001;
  logic [31:0] exp_data [4] = '{32'hA5A5_F0C0, 32'h0123_4500, 32'hFFFF_FFC0, 32'hDEAD_BE00};

  assign req_mant = {M3, M2, M1, M0};
  assign req_k    = {8'hFD, 8'h00, 8'h02, 8'h00};

  always #5 clk = ~clk;

  round_share_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mant  (req_mant),
    .req_k     (req_k),
    .ru_mant   (ru_mant),
    .ru_k      (ru_k),
    .ru_result (ru_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  logic [7:0] abs_k;
  logic [4:0] fw;
  always_comb begin
    abs_k = ru_k[7] ? (8'd0 - ru_k) : ru_k;
    fw    = (abs_k >= 8'd26) ? 5'd0 : 5'(8'd26 - abs_k);
    ru_result = ru_mant[63:32] & ~(32'hFFFF_FFFF >> fw);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check grant and rsp_valid 1 time unit later
  task automatic cyc(input logic [3:0] vld, input logic rdy,
                     input logic [3:0] exp_gnt, input logic exp_rv, input string name);
    exp_t e;
    @(negedge clk);
    req_valid = vld;
    rsp_ready = rdy;
    #1;
    chk({name, ".req_ready"}, {28'd0, req_ready}, {28'd0, exp_gnt});
    chk({name, ".rsp_valid"}, {31'd0, rsp_valid}, {31'd0, exp_rv});
    for (int i = 0; i < 4; i++) begin
      if (exp_gnt[i]) begin
        e.id   = 2'(i);
        e.data = exp_data[i];
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic reset_hold(input int n);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    sb_q.delete();
    #1;
    chk("rst.req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (n) @(negedge clk);
    #1;
    chk("rst.rsp_data", rsp_data, 32'd0);
    chk("rst.rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("rst.req_ready_hold", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'h0;
  endtask

  // Monitor: pops an expected response on every completed handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp.unexpected actual id=%0d data=%0h required=no response", rsp_id, rsp_data);
        end else begin
          e = sb_q.pop_front();
          chk("rsp.id", {30'd0, rsp_id}, {30'd0, e.id});
          chk("rsp.data", rsp_data, e.data);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    reset_hold(2);

`ifdef ROUND_ARB_FIXED_PRIO_EN
    cyc(4'b1001, 1'b1, 4'b0001, 1'b0, "fp1");
    cyc(4'b1001, 1'b1, 4'b0001, 1'b0, "fp2");
    cyc(4'b1001, 1'b1, 4'b0001, 1'b1, "fp3");
    cyc(4'b1001, 1'b1, 4'b0001, 1'b1, "fp4");
    cyc(4'b1001, 1'b1, 4'b0001, 1'b1, "fp5");
    cyc(4'b1001, 1'b1, 4'b0001, 1'b1, "fp6");
    cyc(4'b1000, 1'b1, 4'b1000, 1'b1, "fp7");
    cyc(4'b0000, 1'b1, 4'b0000, 1'b1, "fp8");
    cyc(4'b0000, 1'b1, 4'b0000, 1'b1, "fp9");
    cyc(4'b0000, 1'b1, 4'b0000, 1'b0, "fp10");
`else
    // Round-robin from rr_ptr=0 with all requesters active
    cyc(4'hF, 1'b1, 4'b0001, 1'b0, "rr1");
    cyc(4'hF, 1'b1, 4'b0010, 1'b0, "rr2");
    cyc(4'hF, 1'b1, 4'b0100, 1'b1, "rr3");
    cyc(4'hF, 1'b1, 4'b1000, 1'b1, "rr4");
    cyc(4'hF, 1'b1, 4'b0001, 1'b1, "rr5");
    cyc(4'h0, 1'b1, 4'b0000, 1'b1, "rr6");
    cyc(4'h0, 1'b1, 4'b0000, 1'b1, "rr7");
    cyc(4'h0, 1'b1, 4'b0000, 1'b0, "rr8");

    // Single request, two-clock latency
    cyc(4'b0100, 1'b1, 4'b0100, 1'b0, "one1");
    cyc(4'b0000, 1'b1, 4'b0000, 1'b0, "one2");
    cyc(4'b0000, 1'b1, 4'b0000, 1'b1, "one3");
    chk("one3.rsp_data", rsp_data, 32'hFFFF_FFC0);
    chk("one3.rsp_id", {30'd0, rsp_id}, 32'd2);
    cyc(4'b0000, 1'b1, 4'b0000, 1'b0, "one4");

    // Backpressure: two accepts fill S1/S2, then stall with S2 held
    cyc(4'hF, 1'b0, 4'b1000, 1'b0, "bp_a");
    cyc(4'hF, 1'b0, 4'b0001, 1'b0, "bp_b");
    cyc(4'hF, 1'b0, 4'b0000, 1'b1, "bp_c");
    chk("bp_c.rsp_data", rsp_data, 32'hDEAD_BE00);
    chk("bp_c.rsp_id", {30'd0, rsp_id}, 32'd3);
    cyc(4'hF, 1'b0, 4'b0000, 1'b1, "bp_d");
    chk("bp_d.rsp_data", rsp_data, 32'hDEAD_BE00);
    chk("bp_d.rsp_id", {30'd0, rsp_id}, 32'd3);
    cyc(4'hF, 1'b1, 4'b0010, 1'b1, "bp_e");
    cyc(4'hF, 1'b1, 4'b0100, 1'b1, "bp_f");
    cyc(4'h0, 1'b1, 4'b0000, 1'b1, "bp_g");
    cyc(4'h0, 1'b1, 4'b0000, 1'b1, "bp_h");
    cyc(4'h0, 1'b1, 4'b0000, 1'b0, "bp_i");

    // Reset mid-operation with both stages full (rr_ptr=3 here)
    cyc(4'hF, 1'b1, 4'b1000, 1'b0, "mr1");
    cyc(4'hF, 1'b1, 4'b0001, 1'b0, "mr2");
    reset_hold(1);
    cyc(4'hF, 1'b1, 4'b0001, 1'b0, "mr_r1");
    cyc(4'h0, 1'b1, 4'b0000, 1'b0, "mr_r2");
    cyc(4'h0, 1'b1, 4'b0000, 1'b1, "mr_r3");
    cyc(4'h0, 1'b1, 4'b0000, 1'b0, "mr_r4");
`endif

    for (int n = 0; n < 20 && sb_q.size() != 0; n++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain.pending actual=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
